// File: rtl/cdb_arbiter_if.sv
// Source-result and CDB broadcast signals between the functional units, the arbiter and its consumers.
interface cdb_arbiter_if #(
  parameter int NUM_SRC = 7,
  parameter int DATA_W  = 32,
  parameter int TAG_W   = 4
);
  localparam int SRC_W = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0]        src_valid;
  logic [NUM_SRC*TAG_W-1:0]  src_tag;
  logic [NUM_SRC*DATA_W-1:0] src_data;
  logic [NUM_SRC-1:0]        src_ready;
  logic                      cdb_valid;
  logic [TAG_W-1:0]          cdb_tag;
  logic [DATA_W-1:0]         cdb_data;
  logic [SRC_W-1:0]          cdb_src;

  modport master (
    output src_valid, src_tag, src_data,
    input  src_ready, cdb_valid, cdb_tag, cdb_data, cdb_src
  );

  modport slave (
    input  src_valid, src_tag, src_data,
    output src_ready, cdb_valid, cdb_tag, cdb_data, cdb_src
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: one-deep holding register per result source,
// round-robin grant, one registered broadcast per cycle.

module cdb_hold_entry #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              valid,
  input  logic [TAG_W-1:0]  new_tag,
  input  logic [DATA_W-1:0] new_data,
  input  logic              grant,
  output logic              full,
  output logic [TAG_W-1:0]  tag,
  output logic [DATA_W-1:0] data
);
  // Grant only hits a full entry and accept only an empty one, so they never collide.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      full <= 1'b0;
    end else if (full) begin
      if (grant) full <= 1'b0;
    end else if (valid) begin
      full <= 1'b1;
      tag  <= new_tag;
      data <= new_data;
    end
  end
endmodule

module cdb_arbiter #(
  parameter int NUM_SRC = 7,
  parameter int DATA_W  = 32,
  parameter int TAG_W   = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  cdb_arbiter_if.slave  bus
);
  localparam int SRC_W = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0]             full;
  logic [NUM_SRC-1:0]             grant;
  logic [NUM_SRC-1:0][TAG_W-1:0]  hold_tag;
  logic [NUM_SRC-1:0][DATA_W-1:0] hold_data;
  logic [SRC_W-1:0]               rr_ptr;
  logic [SRC_W-1:0]               gnt_idx;
  logic                           gnt_any;
  logic [SRC_W:0]                 idx;

  logic                           cdb_valid;
  logic [TAG_W-1:0]               cdb_tag;
  logic [DATA_W-1:0]              cdb_data;
  logic [SRC_W-1:0]               cdb_src;

  generate
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_ent
      cdb_hold_entry #(.DATA_W(DATA_W), .TAG_W(TAG_W)) u_ent (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .valid    (bus.src_valid[i]),
        .new_tag  (bus.src_tag[i*TAG_W +: TAG_W]),
        .new_data (bus.src_data[i*DATA_W +: DATA_W]),
        .grant    (grant[i]),
        .full     (full[i]),
        .tag      (hold_tag[i]),
        .data     (hold_data[i])
      );
    end
  endgenerate

  assign bus.src_ready = ~full;

  // Search starts one past the last winner and wraps; first full entry wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    grant   = '0;
    idx     = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      idx = {1'b0, rr_ptr} + (SRC_W+1)'(k);
      if (idx >= (SRC_W+1)'(NUM_SRC)) idx = idx - (SRC_W+1)'(NUM_SRC);
      if (!gnt_any && full[idx[SRC_W-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = idx[SRC_W-1:0];
      end
    end
    grant[gnt_idx] = gnt_any;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
      cdb_src   <= '0;
      rr_ptr    <= SRC_W'(NUM_SRC-1);
    end else if (flush) begin
      cdb_valid <= 1'b0;
    end else begin
      cdb_valid <= gnt_any;
      if (gnt_any) begin
        cdb_tag  <= hold_tag[gnt_idx];
        cdb_data <= hold_data[gnt_idx];
        cdb_src  <= gnt_idx;
        rr_ptr   <= gnt_idx;
      end
    end
  end

  assign bus.cdb_valid = cdb_valid;
  assign bus.cdb_tag   = cdb_tag;
  assign bus.cdb_data  = cdb_data;
  assign bus.cdb_src   = cdb_src;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: directed scenarios plus randomized traffic
// against a behavioural model of holding entries and round-robin order.
module tb_cdb_arbiter;
  localparam int NS = 7;
  localparam int DW = 32;
  localparam int TW = 4;

  typedef struct {
    logic          v;
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
    logic [2:0]    src;
  } exp_t;

  logic clk;
  logic rst;
  logic flush;

  cdb_arbiter_if #(.NUM_SRC(NS), .DATA_W(DW), .TAG_W(TW)) bus ();

  cdb_arbiter #(.NUM_SRC(NS), .DATA_W(DW), .TAG_W(TW)) dut (
    .clk   (clk),
    .reset (rst),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int fails   = 0;
  exp_t sb[$];

  // Model state
  bit            m_full [NS];
  logic [TW-1:0] m_tag  [NS];
  logic [DW-1:0] m_data [NS];
  int            m_ptr;
  exp_t          m_out;
  bit            m_init = 0;

  // Source-side pending results
  logic [NS-1:0]         pend;
  logic [NS-1:0][TW-1:0] ptag;
  logic [NS-1:0][DW-1:0] pdata;

  // One cycle: check ready, predict the coming edge, push expectation, drive inputs.
  task automatic step(input bit r, input bit f, input logic [NS-1:0] v,
                      input logic [NS-1:0][TW-1:0] t, input logic [NS-1:0][DW-1:0] d,
                      output logic [NS-1:0] acc);
    logic [NS-1:0] er;
    int g;
    @(negedge clk);
    acc = '0;
    if (m_init) begin
      for (int i = 0; i < NS; i++) er[i] = !m_full[i];
      vectors++;
      if (bus.src_ready !== er) begin
        fails++;
        $display("FAIL src_ready @%0t: got %b want %b", $time, bus.src_ready, er);
      end
      for (int i = 0; i < NS; i++) acc[i] = v[i] && !m_full[i];
    end
    if (r) begin
      for (int i = 0; i < NS; i++) m_full[i] = 0;
      m_ptr = NS - 1;
      m_out.v = 0; m_out.tag = '0; m_out.data = '0; m_out.src = '0;
      m_init = 1;
    end else if (f) begin
      for (int i = 0; i < NS; i++) m_full[i] = 0;
      m_out.v = 0;
    end else begin
      g = -1;
      for (int k = 1; k <= NS; k++)
        if (g < 0 && m_full[(m_ptr + k) % NS]) g = (m_ptr + k) % NS;
      for (int i = 0; i < NS; i++)
        if (v[i] && !m_full[i]) begin
          m_full[i] = 1; m_tag[i] = t[i]; m_data[i] = d[i];
        end
      if (g >= 0) begin
        m_out.v = 1; m_out.tag = m_tag[g]; m_out.data = m_data[g]; m_out.src = 3'(g);
        m_full[g] = 0;
        m_ptr = g;
      end else begin
        m_out.v = 0;
      end
    end
    sb.push_back(m_out);
    rst           = r;
    flush         = f;
    bus.src_valid = v;
    bus.src_tag   = t;
    bus.src_data  = d;
  endtask

  task automatic idle(input int n);
    logic [NS-1:0] acc;
    for (int c = 0; c < n; c++) step(0, 0, '0, '0, '0, acc);
  endtask

  // Sources present a result and hold it until the handshake completes.
  task automatic run(input int n, input logic [NS-1:0] mask, input int pct,
                     input int flush_pm, input int rst_pm);
    logic [NS-1:0] acc;
    bit r, f;
    for (int c = 0; c < n; c++) begin
      for (int i = 0; i < NS; i++)
        if (mask[i] && !pend[i] && $urandom_range(99) < pct) begin
          pend[i]  = 1'b1;
          ptag[i]  = TW'($urandom);
          pdata[i] = $urandom;
        end
      r = ($urandom_range(999) < rst_pm);
      f = ($urandom_range(999) < flush_pm);
      step(r, f, pend, ptag, pdata, acc);
      if (r) pend = '0;
      else   pend = pend & ~acc;
    end
  endtask

  // Monitor: one expectation per driven cycle, compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        vectors++;
        if (bus.cdb_valid !== e.v || bus.cdb_tag !== e.tag ||
            bus.cdb_data !== e.data || bus.cdb_src !== e.src) begin
          fails++;
          $display("FAIL cdb @%0t: got v=%b tag=%h data=%h src=%0d want v=%b tag=%h data=%h src=%0d",
                   $time, bus.cdb_valid, bus.cdb_tag, bus.cdb_data, bus.cdb_src,
                   e.v, e.tag, e.data, e.src);
        end
      end
    end
  end

  initial begin
    logic [NS-1:0] acc;
    logic [NS-1:0][TW-1:0] t;
    logic [NS-1:0][DW-1:0] d;
    int wait_cyc;
    rst = 1'b1; flush = 1'b0;
    bus.src_valid = '0; bus.src_tag = '0; bus.src_data = '0;
    pend = '0; ptag = '0; pdata = '0;

    step(1, 0, '0, '0, '0, acc);
    step(1, 0, '0, '0, '0, acc);

    // Single result on source 3
    t = '0; d = '0; t[3] = 4'h3; d[3] = 32'h0000_0010;
    step(0, 0, 7'h08, t, d, acc);
    idle(3);

    // All sources in the same cycle
    for (int i = 0; i < NS; i++) begin t[i] = TW'(i); d[i] = DW'(i * 32'h100); end
    step(0, 0, 7'h7F, t, d, acc);
    idle(9);

    // Sources 1 and 5 continuously valid from reset
    step(1, 0, '0, '0, '0, acc);
    pend = '0;
    run(20, 7'b010_0010, 100, 0, 0);
    pend = '0;
    idle(3);

    // Pointer wrap: grant 6, then 0 and 6 both full with rr_ptr=6
    step(1, 0, '0, '0, '0, acc);
    t = '0; d = '0; t[6] = 4'h6; d[6] = 32'hAAAA_0006; t[0] = 4'h0; d[0] = 32'hBBBB_0000;
    step(0, 0, 7'h40, t, d, acc);
    idle(1);
    step(0, 0, 7'h41, t, d, acc);
    idle(4);

    // Flush with entries 2 and 4 full and a same-cycle arrival on 0
    t = '0; d = '0; t[2] = 4'h2; d[2] = 32'h22; t[4] = 4'h4; d[4] = 32'h44; d[0] = 32'h11;
    step(0, 0, 7'h14, t, d, acc);
    step(0, 1, 7'h01, t, d, acc);
    idle(3);

    // Reset while entries are full and a broadcast is in flight
    for (int i = 0; i < NS; i++) begin t[i] = TW'(i + 8); d[i] = DW'(32'h5000 + i); end
    step(0, 0, 7'h0B, t, d, acc);
    idle(1);
    step(1, 0, 7'h7F, t, d, acc);
    step(0, 0, 7'h41, t, d, acc);
    idle(4);

    // Randomized traffic with occasional flush and reset
    step(1, 0, '0, '0, '0, acc);
    pend = '0;
    run(1500, 7'h7F, 40, 10, 3);
    run(1500, 7'h7F, 90, 5, 0);
    pend = '0;
    idle(10);

    wait_cyc = 0;
    while (sb.size() > 0 && wait_cyc < 5) begin
      @(posedge clk);
      wait_cyc++;
    end
    #2;
    if (sb.size() > 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
